snn_delay_layer: RTL and testbench

//  Parametrised leaky integrate-and-fire layer with per-synapse programmable axonal delays.
//  N_IN input spike lines feed N_OUT neurons through a signed weight matrix.

---
 rtl/snn_delay_layer.sv | 193 +++++++++++++++++++
 tb/tb_snn_delay_layer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_delay_layer.sv
// Leaky integrate-and-fire layer: N_IN spike inputs drive N_OUT neurons through a signed
// weight matrix with a programmable axonal delay per synapse, one synapse per cycle.
module snn_delay_layer #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 2,
    parameter int W_BITS     = 8,
    parameter int V_BITS     = 12,
    parameter int D_BITS     = 2,
    parameter int CFG_W      = 16,
    parameter int THRESH_RST = 64,
    localparam int DBG_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     input_ready,
    input  logic [N_IN-1:0]          in_spikes,
    input  logic                     cfg_we,
    input  logic [7:0]               cfg_addr,
    input  logic [CFG_W-1:0]         cfg_data,
    input  logic [DBG_W-1:0]         dbg_sel,
    output logic [N_OUT-1:0]         output_spikes,
    output logic                     data_valid_out,
    output logic                     busy,
    output logic signed [V_BITS-1:0] debug_v
);

    localparam int S         = N_IN * N_OUT;
    localparam int MAX_DELAY = (1 << D_BITS) - 1;
    localparam int IDX_W     = (S > 1) ? $clog2(S) : 1;
    localparam int CH_W      = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NRN_W     = DBG_W;

    typedef enum logic [1:0] {IDLE, LEAK, ACCUM, FIRE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [NRN_W-1:0]           nrn_q, nrn_d;
    logic [N_IN-1:0]            latched_q, latched_d;
    logic [MAX_DELAY:0]         hist_q [N_IN];
    logic [MAX_DELAY:0]         hist_d [N_IN];
    logic signed [V_BITS-1:0]   v_q [N_OUT];
    logic signed [V_BITS-1:0]   v_d [N_OUT];
    logic signed [W_BITS-1:0]   w_q [S];
    logic signed [W_BITS-1:0]   w_d [S];
    logic [D_BITS-1:0]          dly_q [S];
    logic [D_BITS-1:0]          dly_d [S];
    logic [V_BITS-1:0]          thresh_q, thresh_d;
    logic [3:0]                 leak_q, leak_d;
    logic [N_OUT-1:0]           spikes_q, spikes_d;
    logic                       dv_q, dv_d;
    logic                       busy_q, busy_d;
    logic signed [V_BITS-1:0]   dbg_q, dbg_d;
    logic                       unused_cfg;

    assign unused_cfg = ^cfg_data;

    // Add a weight to a membrane, clamping to the representable range instead of wrapping.
    function automatic logic signed [V_BITS-1:0] sat_add(input logic signed [V_BITS-1:0] a,
                                                         input logic signed [W_BITS-1:0] b);
        logic [V_BITS:0] s;
        s = {a[V_BITS-1], a} + {{(V_BITS + 1 - W_BITS){b[W_BITS-1]}}, b};
        if (!s[V_BITS] && s[V_BITS-1])
            return {1'b0, {(V_BITS - 1){1'b1}}};
        else if (s[V_BITS] && !s[V_BITS-1])
            return {1'b1, {(V_BITS - 1){1'b0}}};
        else
            return s[V_BITS-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        nrn_d     = nrn_q;
        latched_d = latched_q;
        hist_d    = hist_q;
        v_d       = v_q;
        w_d       = w_q;
        dly_d     = dly_q;
        thresh_d  = thresh_q;
        leak_d    = leak_q;
        spikes_d  = spikes_q;
        dv_d      = 1'b0;
        busy_d    = busy_q;
        dbg_d     = '0;
        if (int'(dbg_sel) < N_OUT)
            dbg_d = v_q[dbg_sel];

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    if (int'(cfg_addr) < S) begin
                        w_d[cfg_addr[IDX_W-1:0]]   = cfg_data[W_BITS-1:0];
                        dly_d[cfg_addr[IDX_W-1:0]] = cfg_data[W_BITS+D_BITS-1:W_BITS];
                    end else if (int'(cfg_addr) == S) begin
                        thresh_d = cfg_data[V_BITS-1:0];
                    end else if (int'(cfg_addr) == S + 1) begin
                        leak_d = cfg_data[3:0];
                    end
                end
                if (input_ready) begin
                    latched_d = in_spikes;
                    busy_d    = 1'b1;
                    state_d   = LEAK;
                end
            end
            LEAK: begin
                for (int i = 0; i < N_IN; i++)
                    hist_d[i] = {hist_q[i][MAX_DELAY-1:0], latched_q[i]};
                // A zero shift would subtract v from itself, so it means "no leak".
                if (leak_q != 4'd0) begin
                    for (int j = 0; j < N_OUT; j++)
                        v_d[j] = v_q[j] - (v_q[j] >>> leak_q);
                end
                idx_d   = '0;
                ch_d    = '0;
                nrn_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                if (hist_q[ch_q][dly_q[idx_q]])
                    v_d[nrn_q] = sat_add(v_q[nrn_q], w_q[idx_q]);
                idx_d = idx_q + IDX_W'(1);
                if (ch_q == CH_W'(N_IN - 1)) begin
                    ch_d  = '0;
                    nrn_d = nrn_q + NRN_W'(1);
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
                if (idx_q == IDX_W'(S - 1))
                    state_d = FIRE;
            end
            FIRE: begin
                for (int j = 0; j < N_OUT; j++) begin
                    spikes_d[j] = ($signed({v_q[j][V_BITS-1], v_q[j]}) >= $signed({1'b0, thresh_q}));
                    if (spikes_d[j])
                        v_d[j] = '0;
                end
                dv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ch_q      <= '0;
            nrn_q     <= '0;
            latched_q <= '0;
            for (int i = 0; i < N_IN; i++)
                hist_q[i] <= '0;
            for (int j = 0; j < N_OUT; j++)
                v_q[j] <= '0;
            for (int n = 0; n < S; n++) begin
                w_q[n]   <= '0;
                dly_q[n] <= '0;
            end
            thresh_q  <= V_BITS'(THRESH_RST);
            leak_q    <= '0;
            spikes_q  <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            dbg_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ch_q      <= ch_d;
            nrn_q     <= nrn_d;
            latched_q <= latched_d;
            hist_q    <= hist_d;
            v_q       <= v_d;
            w_q       <= w_d;
            dly_q     <= dly_d;
            thresh_q  <= thresh_d;
            leak_q    <= leak_d;
            spikes_q  <= spikes_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            dbg_q     <= dbg_d;
        end
    end

    assign output_spikes  = spikes_q;
    assign data_valid_out = dv_q;
    assign busy           = busy_q;
    assign debug_v        = dbg_q;

endmodule

// File: tb/tb_snn_delay_layer.sv
// Bench for snn_delay_layer: a behavioural integer model predicts each timestep's spikes and
// membrane; predictions queue at drive time and are popped when data_valid_out pulses.
module tb_snn_delay_layer;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int V_BITS = 12;
    localparam int S      = N_IN * N_OUT;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 input_ready;
    logic [N_IN-1:0]      in_spikes;
    logic                 cfg_we;
    logic [7:0]           cfg_addr;
    logic [15:0]          cfg_data;
    logic [0:0]           dbg_sel;
    logic [N_OUT-1:0]     output_spikes;
    logic                 data_valid_out;
    logic                 busy;
    logic [V_BITS-1:0]    debug_v;

    int checks = 0;
    int errors = 0;

    logic [N_OUT-1:0]  exp_q[$];
    logic [V_BITS-1:0] exp_v_q[$];

    int m_w [S];
    int m_d [S];
    int m_v [N_OUT];
    int m_thr;
    int m_leak;
    bit m_hist [N_IN][4];

    snn_delay_layer dut (
        .system_clock   (clk),
        .reset          (reset),
        .input_ready    (input_ready),
        .in_spikes      (in_spikes),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .dbg_sel        (dbg_sel),
        .output_spikes  (output_spikes),
        .data_valid_out (data_valid_out),
        .busy           (busy),
        .debug_v        (debug_v)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int n = 0; n < S; n++) begin
            m_w[n] = 0;
            m_d[n] = 0;
        end
        for (int j = 0; j < N_OUT; j++) m_v[j] = 0;
        for (int i = 0; i < N_IN; i++)
            for (int k = 0; k < 4; k++) m_hist[i][k] = 1'b0;
        m_thr  = 64;
        m_leak = 0;
    endfunction

    function automatic void model_cfg(input int a, input logic [15:0] d);
        if (a < S) begin
            m_w[a] = int'($signed(d[7:0]));
            m_d[a] = int'(d[9:8]);
        end else if (a == S) begin
            m_thr = int'(d[11:0]);
        end else if (a == S + 1) begin
            m_leak = int'(d[3:0]);
        end
    endfunction

    function automatic logic [N_OUT-1:0] model_step(input logic [N_IN-1:0] sp);
        logic [N_OUT-1:0] spk;
        spk = '0;
        for (int i = 0; i < N_IN; i++) begin
            for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = sp[i];
        end
        if (m_leak != 0)
            for (int j = 0; j < N_OUT; j++) m_v[j] = m_v[j] - (m_v[j] >>> m_leak);
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                if (m_hist[i][m_d[j*N_IN+i]]) begin
                    m_v[j] = m_v[j] + m_w[j*N_IN+i];
                    if (m_v[j] > 2047) m_v[j] = 2047;
                    if (m_v[j] < -2048) m_v[j] = -2048;
                end
        for (int j = 0; j < N_OUT; j++)
            if (m_v[j] >= m_thr) begin
                spk[j] = 1'b1;
                m_v[j] = 0;
            end
        return spk;
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
        model_cfg(int'(a), d);
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        input_ready = 1'b0;
        cfg_we      = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One timestep; with inject set, input_ready and a cfg write are pulsed during ACCUM.
    task automatic run_step(input logic [N_IN-1:0] sp, input bit inject);
        int n;
        logic [N_OUT-1:0]  e;
        logic [V_BITS-1:0] ev;
        exp_q.push_back(model_step(sp));
        exp_v_q.push_back(V_BITS'(m_v[dbg_sel]));
        input_ready = 1'b1;
        in_spikes   = sp;
        tick();
        input_ready = 1'b0;
        in_spikes   = N_IN'($urandom_range(0, 15));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got %b expected 1", busy);
        end
        n = 0;
        while (data_valid_out !== 1'b1 && n < 30) begin
            if (inject && n == 4) begin
                input_ready = 1'b1;
                cfg_we      = 1'b1;
                cfg_addr    = 8'd0;
                cfg_data    = 16'h0005;
            end
            tick();
            n++;
            input_ready = 1'b0;
            cfg_we      = 1'b0;
        end
        checks++;
        if (n != S + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", n, S + 2);
        end
        e  = exp_q.pop_front();
        ev = exp_v_q.pop_front();
        checks++;
        if (output_spikes !== e) begin
            errors++;
            $display("FAIL spikes: got %b expected %b", output_spikes, e);
        end
        tick();
        checks++;
        if (debug_v !== ev) begin
            errors++;
            $display("FAIL debug_v: got %0d expected %0d", $signed(debug_v), $signed(ev));
        end
        checks++;
        if (data_valid_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dv_pulse: got dv=%b busy=%b expected 0 0", data_valid_out, busy);
        end
    endtask

    task automatic test_reset();
        in_spikes = '0;
        cfg_addr  = '0;
        cfg_data  = '0;
        dbg_sel   = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();
        apply_reset();
        checks++;
        if (output_spikes !== 2'b00 || busy !== 1'b0 || debug_v !== '0 || data_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got spk=%b busy=%b v=%0d dv=%b expected 0 0 0 0",
                     output_spikes, busy, debug_v, data_valid_out);
        end
        run_step(4'hF, 1'b0);
    endtask

    task automatic test_accum();
        cfg_write(8'd0, 16'h000C);
        cfg_write(8'd8, 16'd20);
        run_step(4'b0001, 1'b0);
        run_step(4'b0001, 1'b0);
        checks++;
        if (output_spikes !== 2'b01) begin
            errors++;
            $display("FAIL accum_fire: got %b expected 01", output_spikes);
        end
    endtask

    task automatic test_delay();
        dbg_sel = 1'b1;
        cfg_write(8'd6, 16'h021E);
        cfg_write(8'd8, 16'd25);
        run_step(4'b0100, 1'b0);
        run_step(4'b0000, 1'b0);
        run_step(4'b0000, 1'b0);
        checks++;
        if (output_spikes !== 2'b10) begin
            errors++;
            $display("FAIL delay_fire: got %b expected 10", output_spikes);
        end
        dbg_sel = 1'b0;
    endtask

    task automatic test_saturation();
        cfg_write(8'd0, 16'h0080);
        for (int s = 0; s < 20; s++) run_step(4'b0001, 1'b0);
        checks++;
        if (debug_v !== 12'h800) begin
            errors++;
            $display("FAIL sat_low: got %0d expected -2048", $signed(debug_v));
        end
        cfg_write(8'd0, 16'h007F);
        cfg_write(8'd8, 16'd2047);
        for (int s = 0; s < 33; s++) run_step(4'b0001, 1'b0);
        checks++;
        if (output_spikes[0] !== 1'b1 || debug_v !== '0) begin
            errors++;
            $display("FAIL sat_high: got spk=%b v=%0d expected 1 0", output_spikes[0], debug_v);
        end
    endtask

    task automatic test_leak_busy();
        cfg_write(8'd0, 16'h0040);
        run_step(4'b0001, 1'b0);
        cfg_write(8'd9, 16'h0001);
        run_step(4'b0000, 1'b1);
        checks++;
        if (debug_v !== 12'd32) begin
            errors++;
            $display("FAIL leak_half: got %0d expected 32", $signed(debug_v));
        end
        run_step(4'b0001, 1'b0);
        checks++;
        if (debug_v !== 12'd80) begin
            errors++;
            $display("FAIL busy_ignored: got %0d expected 80", $signed(debug_v));
        end
    endtask

    task automatic test_reset_mid();
        bit saw_dv;
        input_ready = 1'b1;
        in_spikes   = 4'b0001;
        tick();
        input_ready = 1'b0;
        repeat (4) tick();
        apply_reset();
        checks++;
        if (busy !== 1'b0 || output_spikes !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b spk=%b expected 0 00", busy, output_spikes);
        end
        saw_dv = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (data_valid_out === 1'b1) saw_dv = 1'b1;
        end
        checks++;
        if (saw_dv || debug_v !== '0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got dv_seen=%b v=%0d expected 0 0", saw_dv, debug_v);
        end
        cfg_write(8'd0, 16'h0128);
        run_step(4'b0000, 1'b0);
        run_step(4'b0001, 1'b0);
        run_step(4'b0001, 1'b0);
        run_step(4'b0000, 1'b0);
        checks++;
        if (output_spikes !== 2'b01) begin
            errors++;
            $display("FAIL thresh_reset: got %b expected 01", output_spikes);
        end
    endtask

    initial begin
        test_reset();
        test_accum();
        test_delay();
        test_saturation();
        test_leak_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
